// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port arbiter for the single-port data memory
// Grants one word access per cycle, rejects illegal addresses, returns registered read data.
module dm_arbiter #(
  parameter int unsigned MEM_BYTES   = 128,
  parameter bit          P0_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [1:0]  err_sticky,
  input  logic        err_clr,
  output logic        dm_mem_read,
  output logic        dm_mem_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_read_data
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  logic        last_grant;
  logic        pend_valid;
  logic        pend_port;
  logic [1:0]  err_q;
  logic [1:0]  new_err;
  logic        legal0;
  logic        legal1;
  logic        pick0;
  logic        sel_legal;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // Full 32-bit compare so large addresses never alias into the memory.
  assign legal0 = (addr0[1:0] == 2'b00) && (addr0 <= LAST_WORD);
  assign legal1 = (addr1[1:0] == 2'b00) && (addr1 <= LAST_WORD);

  always_comb begin
    pick0 = P0_PRIORITY ? 1'b1 : last_grant;
    gnt0  = rst_n & req0 & (~req1 | pick0);
    gnt1  = rst_n & req1 & (~req0 | ~pick0);
  end

  always_comb begin
    sel_we    = gnt1 ? we1    : we0;
    sel_addr  = gnt1 ? addr1  : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
    sel_legal = (gnt0 & legal0) | (gnt1 & legal1);
    new_err   = {gnt1 & ~legal1, gnt0 & ~legal0};
  end

  // A rejected grant still consumes the slot but never reaches the memory.
  always_comb begin
    dm_mem_read   = sel_legal & ~sel_we;
    dm_mem_write  = sel_legal & sel_we;
    dm_addr       = sel_legal ? sel_addr : 32'h0;
    dm_write_data = (sel_legal & sel_we) ? sel_wdata : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      pend_valid <= 1'b0;
      pend_port  <= 1'b0;
      err_q      <= 2'b00;
      err_sticky <= 2'b00;
    end else begin
      if (gnt0 | gnt1) begin
        last_grant <= gnt1;
      end
      pend_valid <= dm_mem_read;
      pend_port  <= gnt1;
      err_q      <= new_err;
      err_sticky <= (err_clr ? 2'b00 : err_sticky) | new_err;
    end
  end

  always_comb begin
    rvalid0 = pend_valid & ~pend_port;
    rvalid1 = pend_valid & pend_port;
    rdata0  = rvalid0 ? dm_read_data : 32'h0;
    rdata1  = rvalid1 ? dm_read_data : 32'h0;
    err0    = err_q[0];
    err1    = err_q[1];
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter with a behavioural data memory
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, err_clr;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  err_sticky;
  logic        dm_mem_read, dm_mem_write;
  logic [31:0] dm_addr, dm_write_data, dm_read_data;

  logic        p_req0, p_req1;
  logic [31:0] p_addr0, p_addr1;
  logic        p_gnt0, p_gnt1, p_rvalid0, p_rvalid1, p_err0, p_err1;
  logic [31:0] p_rdata0, p_rdata1, p_dm_addr, p_dm_wdata;
  logic [1:0]  p_err_sticky;
  logic        p_dm_rd, p_dm_wr;

  always #5 clk = ~clk;

  dm_arbiter #(.MEM_BYTES(128), .P0_PRIORITY(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .err_sticky(err_sticky), .err_clr(err_clr),
    .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
    .dm_addr(dm_addr), .dm_write_data(dm_write_data), .dm_read_data(dm_read_data)
  );

  dm_arbiter #(.MEM_BYTES(128), .P0_PRIORITY(1'b1)) u_pri (
    .clk(clk), .rst_n(rst_n),
    .req0(p_req0), .req1(p_req1), .we0(1'b0), .we1(1'b0),
    .addr0(p_addr0), .addr1(p_addr1), .wdata0(32'h0), .wdata1(32'h0),
    .gnt0(p_gnt0), .gnt1(p_gnt1), .rvalid0(p_rvalid0), .rvalid1(p_rvalid1),
    .rdata0(p_rdata0), .rdata1(p_rdata1), .err0(p_err0), .err1(p_err1),
    .err_sticky(p_err_sticky), .err_clr(1'b0),
    .dm_mem_read(p_dm_rd), .dm_mem_write(p_dm_wr),
    .dm_addr(p_dm_addr), .dm_write_data(p_dm_wdata), .dm_read_data(32'h0)
  );

  logic [31:0] mem [0:31];
  logic [31:0] mem_rdata;
  always @(posedge clk) begin
    if (dm_mem_write) mem[dm_addr[6:2]] <= dm_write_data;
    if (dm_mem_read)  mem_rdata <= mem[dm_addr[6:2]];
  end
  assign dm_read_data = mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int exp_last = 1;
  logic [31:0] ref_mem [0:31];

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'd124);
  endfunction

  task automatic push(input int p, input logic [31:0] a);
    exp_t e;
    e.due  = cyc_n + 1;
    e.data = ref_mem[a[6:2]];
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_spurious", 32'h1, 32'h0);
      else begin
        e = q0.pop_front();
        chk("rdata0", rdata0, e.data);
        chk("rvalid0_cycle", cyc_n, e.due);
      end
    end else chk("rdata0_idle", rdata0, 32'h0);
    if (rvalid1) begin
      if (q1.size() == 0) chk("rvalid1_spurious", 32'h1, 32'h0);
      else begin
        e = q1.pop_front();
        chk("rdata1", rdata1, e.data);
        chk("rvalid1_cycle", cyc_n, e.due);
      end
    end else chk("rdata1_idle", rdata1, 32'h0);
    chk("strobe_excl", 32'(dm_mem_read & dm_mem_write), 32'h0);
  end

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Called and returns at posedge+1; the access is granted within at most 4 cycles.
  task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic got;
    logic lg;
    got = 1'b0;
    lg  = legal(a);
    set_port(p, 1'b1, w, a, d);
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? gnt0 : gnt1) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("gnt", 32'(got), 32'h1);
    if (got) begin
      chk("gnt_other", 32'((p == 0) ? gnt1 : gnt0), 32'h0);
      chk("dm_mem_read", 32'(dm_mem_read), 32'(lg & ~w));
      chk("dm_mem_write", 32'(dm_mem_write), 32'(lg & w));
      chk("dm_addr", dm_addr, lg ? a : 32'h0);
      if (lg && w) begin
        chk("dm_write_data", dm_write_data, d);
        ref_mem[a[6:2]] = d;
      end
      if (lg && !w) push(p, a);
      exp_last = p;
    end
    @(posedge clk); #1;
    set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ep;
    rst_n = 1'b0; err_clr = 1'b0;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    p_req0 = 1'b0; p_req1 = 1'b0; p_addr0 = 32'h0; p_addr1 = 32'h4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'h0);
    chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'h0);
    chk("rst_err", 32'({err1, err0}), 32'h0);
    chk("rst_sticky", 32'(err_sticky), 32'h0);
    chk("rst_strobes", 32'({dm_mem_read, dm_mem_write}), 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single port-1 write then read
    access(1, 1'b1, 32'h10, 32'hDEADBEEF);
    access(1, 1'b0, 32'h10, 32'h0);
    access(1, 1'b1, 32'h00, 32'h11111111);
    access(1, 1'b1, 32'h04, 32'h22222222);
    access(1, 1'b1, 32'h7C, 32'h7C7C0001);

    // Sustained conflict: round-robin alternates starting with port 0
    set_port(0, 1'b1, 1'b0, 32'h00, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h04, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ep = (exp_last == 1) ? 0 : 1;
      chk("rr_gnt0", 32'(gnt0), 32'(ep == 0));
      chk("rr_gnt1", 32'(gnt1), 32'(ep == 1));
      push(ep, (ep == 0) ? 32'h00 : 32'h04);
      exp_last = ep;
      @(posedge clk); #1;
    end
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Illegal addresses: misaligned, one past the end, far out of range
    access(0, 1'b0, 32'h7D, 32'h0);
    chk("err0_7d", 32'(err0), 32'h1);
    chk("sticky_7d", 32'(err_sticky), 32'h1);
    access(0, 1'b0, 32'h80, 32'h0);
    chk("err0_80", 32'(err0), 32'h1);
    access(0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    chk("err0_wrap", 32'(err0), 32'h1);
    access(0, 1'b0, 32'h7C, 32'h0);
    chk("err0_7c", 32'(err0), 32'h0);
    chk("sticky_hold", 32'(err_sticky), 32'h1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("sticky_clr", 32'(err_sticky), 32'h0);

    // err_clr coinciding with a new error: the error wins
    err_clr = 1'b1;
    access(1, 1'b0, 32'h02, 32'h0);
    err_clr = 1'b0;
    chk("err1_pulse", 32'(err1), 32'h1);
    chk("sticky_newerr", 32'(err_sticky), 32'h2);
    @(posedge clk); #1;
    chk("err1_one_cycle", 32'(err1), 32'h0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("sticky_clr2", 32'(err_sticky), 32'h0);

    // Write then read back-to-back on port 0
    access(0, 1'b1, 32'h20, 32'h0000CAFE);
    access(0, 1'b0, 32'h20, 32'h0);
    @(posedge clk); #1;

    // Reset while a granted read is pending at the next edge
    set_port(0, 1'b1, 1'b0, 32'h04, 32'h0);
    @(negedge clk);
    chk("mid_gnt", 32'(gnt0), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'({gnt1, gnt0}), 32'h0);
    chk("mid_rst_strobes", 32'({dm_mem_read, dm_mem_write}), 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_rvalid", 32'({rvalid1, rvalid0}), 32'h0);
    chk("mid_rst_dm_addr", dm_addr, 32'h0);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    exp_last = 1;
    set_port(0, 1'b1, 1'b0, 32'h00, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h04, 32'h0);
    @(negedge clk);
    chk("post_rst_gnt0", 32'(gnt0), 32'h1);
    chk("post_rst_gnt1", 32'(gnt1), 32'h0);
    if (gnt0) push(0, 32'h00);
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fixed priority: port 0 always wins, port 1 gets the slot once req0 drops
    p_req0 = 1'b1; p_req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pri_gnt0", 32'(p_gnt0), 32'h1);
      chk("pri_gnt1", 32'(p_gnt1), 32'h0);
      @(posedge clk); #1;
    end
    p_req0 = 1'b0;
    @(negedge clk);
    chk("pri_gnt1_release", 32'(p_gnt1), 32'h1);
    @(posedge clk); #1;
    p_req1 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
